// File: rtl/vga_sync_gen_if.sv
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Pixel-enable input and VGA timing outputs of vga_sync_gen.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vga_sync_gen_if #(
    parameter int CW = 10
);
    logic          pix_ce;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  pix_ce,
        output hsync, vsync, video_on, x, y, line_start, frame_start
    );

    modport slave (
        output pix_ce,
        input  hsync, vsync, video_on, x, y, line_start, frame_start
    );
endinterface

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster counters with registered sync/blank/pulse decode.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_sync_gen #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   CW          = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);
    localparam int            c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int            c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] c_H_LAST  = CW'(c_H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST  = CW'(c_V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_VIS   = CW'(H_VISIBLE);
    localparam logic [CW-1:0] c_HS_BEG  = CW'(H_VISIBLE + H_FP);
    localparam logic [CW-1:0] c_HS_END  = CW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_V_VIS   = CW'(V_VISIBLE);
    localparam logic [CW-1:0] c_VS_BEG  = CW'(V_VISIBLE + V_FP);
    localparam logic [CW-1:0] c_VS_END  = CW'(V_VISIBLE + V_FP + V_SYNC);

    logic [CW-1:0] r_x, r_y;
    logic          r_hsync, r_vsync, r_video_on, r_line_start, r_frame_start;

    logic [CW-1:0] w_x_nxt, w_y_nxt;
    logic          w_x_wrap, w_y_wrap, w_line_wrap, w_frame_wrap;
    logic          w_hsync, w_vsync, w_video_on;

    always_comb begin
        w_x_wrap     = (r_x == c_H_LAST);
        w_y_wrap     = (r_y == c_V_LAST);
        w_line_wrap  = vga.pix_ce && w_x_wrap;
        w_frame_wrap = w_line_wrap && w_y_wrap;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        if (vga.pix_ce) begin
            w_x_nxt = w_x_wrap ? '0 : r_x + CW'(1);
        end
        if (w_line_wrap) begin
            w_y_nxt = w_y_wrap ? '0 : r_y + CW'(1);
        end
    end

    // Decoding the next-state counters keeps the registered syncs aligned
    // with the registered coordinates; on a stall the decode simply repeats.
    always_comb begin
        w_video_on = (w_x_nxt < c_H_VIS) && (w_y_nxt < c_V_VIS);
        w_hsync    = ((w_x_nxt >= c_HS_BEG) && (w_x_nxt < c_HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        w_vsync    = ((w_y_nxt >= c_VS_BEG) && (w_y_nxt < c_VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_video_on    <= 1'b1;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_video_on    <= w_video_on;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
        end
    end

    assign vga.x           = r_x;
    assign vga.y           = r_y;
    assign vga.video_on    = r_video_on;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Bench for vga_sync_gen: 640x480 instance at 1-in-4 enable and
//               a tiny SYNC_ACTIVE=1 instance with continuous enable.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;
    typedef struct {
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic von;
        logic ls;
        logic fs;
    } exp_t;

    typedef struct {
        int   steps;
        int   x;
        int   y;
        logic hs;
        logic von;
        logic ls;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_sync_gen_if #(.CW(10)) va ();
    vga_sync_gen_if #(.CW(4))  vb ();

    vga_sync_gen dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (va)
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE(1'b1), .CW(4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vb)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ax = 0, ay = 0, bx = 0, by = 0;
    int   cycle = 0;
    int   ls_a_times[$];
    int   fs_b_times[$];
    exp_t qa[$];
    exp_t qb[$];
    vec_t tbl[12];

    always @(posedge clk) cycle++;
    always @(negedge clk) begin
        if (va.line_start === 1'b1) ls_a_times.push_back(cycle);
        if (vb.frame_start === 1'b1) fs_b_times.push_back(cycle);
    end

    task automatic check1(input string nm, input integer got, input integer want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic chk(input string nm, input exp_t e, input integer x, input integer y,
                       input logic hs, input logic vs, input logic von, input logic ls, input logic fs);
        n_cmp++;
        if (x !== e.x || y !== e.y || hs !== e.hs || vs !== e.vs || von !== e.von ||
            ls !== e.ls || fs !== e.fs) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b",
                     nm, cycle, x, y, hs, vs, von, ls, fs, e.x, e.y, e.hs, e.vs, e.von, e.ls, e.fs);
        end
    endtask

    // 640x480 reference: 800 x 525 raster, active-low syncs at 656..751 / 490..491
    task automatic model_a(input bit ce, output exp_t e);
        bit wrap_x, wrap_y;
        wrap_x = ce && (ax == 799);
        wrap_y = wrap_x && (ay == 524);
        if (ce) ax = wrap_x ? 0 : ax + 1;
        if (wrap_x) ay = wrap_y ? 0 : ay + 1;
        e.x = ax; e.y = ay;
        e.hs  = !(ax >= 656 && ax <= 751);
        e.vs  = !(ay == 490 || ay == 491);
        e.von = (ax < 640) && (ay < 480);
        e.ls  = wrap_x;
        e.fs  = wrap_y;
    endtask

    // Tiny reference: 12 x 7 raster, active-high syncs at x=9..10 / y=5
    task automatic model_b(input bit ce, output exp_t e);
        bit wrap_x, wrap_y;
        wrap_x = ce && (bx == 11);
        wrap_y = wrap_x && (by == 6);
        if (ce) bx = wrap_x ? 0 : bx + 1;
        if (wrap_x) by = wrap_y ? 0 : by + 1;
        e.x = bx; e.y = by;
        e.hs  = (bx == 9 || bx == 10);
        e.vs  = (by == 5);
        e.von = (bx < 8) && (by < 4);
        e.ls  = wrap_x;
        e.fs  = wrap_y;
    endtask

    task automatic tick(input bit cea, input bit ceb);
        exp_t ea, eb;
        va.pix_ce = cea;
        vb.pix_ce = ceb;
        model_a(cea, ea);
        model_b(ceb, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clk);
        #1;
        chk("seq_a", qa.pop_front(), va.x, va.y, va.hsync, va.vsync, va.video_on, va.line_start, va.frame_start);
        chk("seq_b", qb.pop_front(), vb.x, vb.y, vb.hsync, vb.vsync, vb.video_on, vb.line_start, vb.frame_start);
    endtask

    // One pixel step on A at 1-in-4; the sample afterwards reflects the step itself
    task automatic advance();
        repeat (3) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
    endtask

    task automatic check_reset_values(input string nm);
        check1({nm, "_ax"}, va.x, 0);
        check1({nm, "_ay"}, va.y, 0);
        check1({nm, "_ahs"}, va.hsync, 1);
        check1({nm, "_avs"}, va.vsync, 1);
        check1({nm, "_avon"}, va.video_on, 1);
        check1({nm, "_als"}, va.line_start, 0);
        check1({nm, "_afs"}, va.frame_start, 0);
        check1({nm, "_bx"}, vb.x, 0);
        check1({nm, "_by"}, vb.y, 0);
        check1({nm, "_bhs"}, vb.hsync, 0);
        check1({nm, "_bvs"}, vb.vsync, 0);
        check1({nm, "_bvon"}, vb.video_on, 1);
    endtask

    initial begin
        int adv;
        int guard;
        tbl[0]  = '{0,    0,   0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{639,  639, 0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{640,  640, 0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{655,  655, 0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{656,  656, 0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{751,  751, 0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{752,  752, 0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{799,  799, 0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{800,  0,   1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{801,  1,   1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1600, 0,   2, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1640, 40,  2, 1'b1, 1'b1, 1'b0};

        va.pix_ce = 1'b0;
        vb.pix_ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Landmarks along the first lines of A, B free-running alongside
        adv = 0;
        for (int i = 0; i < 12; i++) begin
            while (adv < tbl[i].steps) begin
                advance();
                adv++;
            end
            check1($sformatf("tbl%0d_x", i), va.x, tbl[i].x);
            check1($sformatf("tbl%0d_y", i), va.y, tbl[i].y);
            check1($sformatf("tbl%0d_hs", i), va.hsync, tbl[i].hs);
            check1($sformatf("tbl%0d_von", i), va.video_on, tbl[i].von);
            check1($sformatf("tbl%0d_ls", i), va.line_start, tbl[i].ls);
        end

        check1("ls_a_count", ls_a_times.size(), 2);
        if (ls_a_times.size() >= 2)
            check1("ls_a_period", ls_a_times[1] - ls_a_times[0], 3200);
        check1("fs_b_seen", (fs_b_times.size() >= 2) ? 1 : 0, 1);
        if (fs_b_times.size() >= 2)
            check1("fs_b_period", fs_b_times[1] - fs_b_times[0], 84);

        // Stall at x=655 then step into the hsync pulse
        guard = 0;
        while (ax != 655 && guard < 2000) begin
            advance();
            guard++;
        end
        check1("stall_reach", ax, 655);
        repeat (50) tick(1'b0, 1'b1);
        check1("stall_x", va.x, 655);
        check1("stall_hs", va.hsync, 1);
        tick(1'b1, 1'b1);
        check1("post_stall_x", va.x, 656);
        check1("post_stall_hs", va.hsync, 0);
        check1("post_stall_ls", va.line_start, 0);

        // Asynchronous reset mid-line at x=300
        guard = 0;
        while (ax != 300 && guard < 2000) begin
            advance();
            guard++;
        end
        check1("mid_reach", ax, 300);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        ax = 0; ay = 0; bx = 0; by = 0;
        va.pix_ce = 1'b1;
        vb.pix_ce = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("held_rst");
        rst_n = 1'b1;

        // Restart: first wrap after 800 steps, no pulse before it
        for (int i = 0; i < 820; i++) advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
